unit_core_dispatch: RTL
=======================

UNIT_CORE_DISPATCH -- requirements
Module: unit_core_dispatch

Interface
REQ-001 Parameter NUM_CORES, default 16: number of core channels, range 1..32.
REQ-002 Parameter REC_WIDTH, default 112: width of one word record.
REQ-003 Parameter DIN_WIDTH, default 16: broadcast chunk width.
REQ-004 Parameter ADDR_W, default 3: chunk address width; NUM_CHUNKS = ceil(REC_WIDTH/DIN_WIDTH) SHALL be at most 2**ADDR_W (elaboration error otherwise).
REQ-005 CLK  in  1  sole clock; all logic on its rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 DUMMY_CORES  in  NUM_CORES  1 = channel excluded from dispatch.
REQ-008 din  in  REC_WIDTH  record; sampled when wr_en=1 and full=0.
REQ-009 bcast  in  1  broadcast flag, sampled with din.
REQ-010 wr_en  in  1  write strobe.
REQ-011 full  out  1  input slot occupied.
REQ-012 crypt_ready  in  NUM_CORES  core can accept a record.
REQ-013 core_wr_en  out  NUM_CORES  per-core chunk write strobe.
REQ-014 core_din  out  DIN_WIDTH  shared chunk bus.
REQ-015 core_addr_in  out  ADDR_W  chunk index on core_din.
REQ-016 idle  out  1  slot empty and FSM in IDLE.
REQ-017 err  out  1  sticky: record pending with every channel dummy.
REQ-018 num_dispatched  out  32  records fully sent, wraps 0xFFFFFFFF->0.

Function
REQ-019 Single-entry input slot; a write while full=1 SHALL be ignored.
REQ-020 FSM states IDLE, SELECT, SEND; IDLE->SELECT when slot full; SELECT->SEND when a target exists; SEND->IDLE after chunk NUM_CHUNKS-1.
REQ-021 SELECT: round-robin search starting at last_core+1 (mod NUM_CORES) for the first channel with crypt_ready=1 and DUMMY_CORES=0; FSM stays in SELECT while none found.
REQ-022 SEND: cycle k (k=0..NUM_CHUNKS-1) drives core_din = din[k*DIN_WIDTH +: DIN_WIDTH] (zero-padded above REC_WIDTH), core_addr_in=k, core_wr_en one-hot at target.
REQ-023 crypt_ready deasserting during SEND SHALL NOT abort or pause the transfer.
REQ-024 On the last SEND cycle: slot freed (full=0 next cycle), last_core := target, num_dispatched += 1.
REQ-025 Latency: record written at cycle t with a ready target -> first chunk at t+2, full drops at t+2+NUM_CHUNKS.
REQ-026 A write in the cycle after full drops SHALL be accepted; maximum throughput one record per NUM_CHUNKS+2 cycles.
REQ-027 Outside SEND: core_wr_en=0, core_din=0, core_addr_in=0.
REQ-028 err SHALL set when slot full and DUMMY_CORES all ones; cleared only by reset; record held.
REQ-029 DUMMY_CORES changing during SEND SHALL NOT affect the current transfer.

Reset
REQ-030 RST_N=0 SHALL immediately force: full=0, core_wr_en=0, core_din=0, core_addr_in=0, err=0, num_dispatched=0, idle=1, FSM=IDLE, last_core=NUM_CORES-1.
REQ-031 Reset mid-SEND SHALL discard the record; no further chunks emitted.
REQ-032 Writes are ignored while RST_N=0 and on the first edge after release.

Configuration
REQ-033 Macro DISPATCH_BROADCAST_EN defined: a record with bcast=1 waits in SELECT until every non-dummy channel has crypt_ready=1, then SEND drives core_wr_en = ~DUMMY_CORES on all chunks; num_dispatched += 1; last_core unchanged.
REQ-034 Macro undefined: bcast ignored; all records unicast per REQ-021.

Verification
REQ-035 NUM_CORES=4, all ready, 4 records back-to-back -> targets 0,1,2,3, num_dispatched=4.
REQ-036 DUMMY_CORES=4'b0101, all ready, 3 records -> targets 1,3,1.
REQ-037 REC_WIDTH=112, din=0x0001_0002_..._0007 -> addr 0..6 carry 0x0007..0x0001 in 7 consecutive cycles, first at t+2.
REQ-038 DUMMY_CORES=4'b1111, one record -> err=1 next cycle, full stays 1, no core_wr_en.
REQ-039 RST_N=0 during chunk 3 -> outputs zero same cycle; after release idle=1, num_dispatched=0.
REQ-040 DISPATCH_BROADCAST_EN, DUMMY_CORES=4'b1000, core 2 not ready, bcast=1 -> held; core 2 ready -> core_wr_en=4'b0111 for all chunks.

Source files
------------

// File: rtl/unit_core_dispatch.sv
// rtl/unit_core_dispatch.sv - single-slot record dispatcher, round-robin chunked fan-out to cores
// Optional broadcast mode: define DISPATCH_BROADCAST_EN.
module unit_core_dispatch #(
  parameter int NUM_CORES = 16,
  parameter int REC_WIDTH = 112,
  parameter int DIN_WIDTH = 16,
  parameter int ADDR_W    = 3
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_CORES-1:0] DUMMY_CORES,
  input  logic [REC_WIDTH-1:0] din,
  input  logic                 bcast,
  input  logic                 wr_en,
  output logic                 full,
  input  logic [NUM_CORES-1:0] crypt_ready,
  output logic [NUM_CORES-1:0] core_wr_en,
  output logic [DIN_WIDTH-1:0] core_din,
  output logic [ADDR_W-1:0]    core_addr_in,
  output logic                 idle,
  output logic                 err,
  output logic [31:0]          num_dispatched
);

  localparam int NUM_CHUNKS = (REC_WIDTH + DIN_WIDTH - 1) / DIN_WIDTH;
  localparam int PAD_W      = NUM_CHUNKS * DIN_WIDTH;
  localparam int LC_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  if (NUM_CHUNKS > (1 << ADDR_W)) begin : g_addr_chk
    $error("unit_core_dispatch: ADDR_W too small for NUM_CHUNKS");
  end
  if (NUM_CORES < 1 || NUM_CORES > 32) begin : g_cores_chk
    $error("unit_core_dispatch: NUM_CORES out of range 1..32");
  end

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_SEND} state_t;

  state_t               r_state, w_next;
  logic                 r_full, r_armed, r_bcast, r_err;
  logic [REC_WIDTH-1:0] r_din;
  logic [NUM_CORES-1:0] r_mask, w_mask, w_elig, w_onehot;
  logic [LC_W-1:0]      r_last, r_target, w_target;
  logic [ADDR_W-1:0]    r_chunk;
  logic [31:0]          r_count;
  logic [PAD_W-1:0]     w_padded;
  logic                 w_found, w_go, w_accept, w_last_chunk, w_is_bcast, w_send;
  int                   w_idx;

  // r_armed blocks the write on the first edge after reset release
  assign w_accept     = wr_en & ~r_full & r_armed;
  assign w_send       = (r_state == S_SEND);
  assign w_last_chunk = w_send && (r_chunk == ADDR_W'(NUM_CHUNKS - 1));
  assign w_elig       = crypt_ready & ~DUMMY_CORES;
  assign w_onehot     = NUM_CORES'(1) << w_target;
  assign w_padded     = PAD_W'(r_din);

  always_comb begin
    w_found  = 1'b0;
    w_target = '0;
    w_idx    = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_idx = int'(r_last) + 1 + i;
      if (w_idx >= NUM_CORES) w_idx = w_idx - NUM_CORES;
      if (!w_found && 1'(w_elig >> w_idx)) begin
        w_found  = 1'b1;
        w_target = LC_W'(w_idx);
      end
    end
  end

`ifdef DISPATCH_BROADCAST_EN
  assign w_is_bcast = r_bcast;
  assign w_go       = r_bcast ? ((&(crypt_ready | DUMMY_CORES)) && !(&DUMMY_CORES)) : w_found;
  assign w_mask     = r_bcast ? ~DUMMY_CORES : w_onehot;
`else
  logic w_unused_bcast;
  assign w_unused_bcast = r_bcast;
  assign w_is_bcast     = 1'b0;
  assign w_go           = w_found;
  assign w_mask         = w_onehot;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (r_full || w_accept) w_next = S_SELECT;
      S_SELECT: if (w_go) w_next = S_SEND;
      S_SEND:   if (w_last_chunk) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_armed  <= 1'b0;
      r_full   <= 1'b0;
      r_din    <= '0;
      r_bcast  <= 1'b0;
      r_err    <= 1'b0;
      r_mask   <= '0;
      r_target <= '0;
      r_last   <= LC_W'(NUM_CORES - 1);
      r_chunk  <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
      if (w_accept) begin
        r_full  <= 1'b1;
        r_din   <= din;
        r_bcast <= bcast;
      end
      // Mask and target are latched so ready/dummy changes cannot disturb a transfer
      if (r_state == S_SELECT && w_go) begin
        r_mask   <= w_mask;
        r_target <= w_target;
        r_chunk  <= '0;
      end
      if (w_send) begin
        r_chunk <= r_chunk + ADDR_W'(1);
        if (w_last_chunk) begin
          r_full  <= 1'b0;
          r_count <= r_count + 32'd1;
          if (!w_is_bcast) r_last <= r_target;
        end
      end
      if (r_full && (&DUMMY_CORES)) r_err <= 1'b1;
    end
  end

  assign full           = r_full;
  assign idle           = ~r_full & (r_state == S_IDLE);
  assign err            = r_err;
  assign num_dispatched = r_count;
  assign core_wr_en     = w_send ? r_mask : '0;
  assign core_addr_in   = w_send ? r_chunk : '0;
  assign core_din       = w_send ? DIN_WIDTH'(w_padded >> (r_chunk * DIN_WIDTH)) : '0;

endmodule
